// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with skip/branch/wfi/rfi flow and a single-level shadow PC
module pc_sequencer #(
    parameter int unsigned PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0] IRQ_VECTOR = PC_WIDTH'(4)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic [1:0]          pc_mux,
    input  logic                pc_save,
    input  logic                skip,
    input  logic [PC_WIDTH-1:0] literal,
    input  logic [PC_WIDTH-1:0] wreg,
    input  logic                irq,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] saved_pc,
    output logic                in_isr,
    output logic                waiting,
    output logic                irq_ack
);
    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    logic [PC_WIDTH-1:0] pc_q, pc_d, saved_q, saved_d, inc1, inc2, npc;
    logic [0:0] state_q, state_d;
    logic isr_q, isr_d, ack_q, ack_d;
    logic run, is_rfi, wfi_go, take, wake, adv;
    always_comb begin
        inc1 = pc_q + PC_WIDTH'(1);
        inc2 = pc_q + PC_WIDTH'(2);
        run = state_q == RUN;
        is_rfi = pc_mux == 2'd3 && !pc_save && isr_q;
        wfi_go = run && pc_mux == 2'd3 && pc_save && !isr_q;
        npc = pc_mux == 2'd0 ? (skip ? inc2 : inc1) :
              pc_mux == 2'd1 ? wreg :
              pc_mux == 2'd2 ? literal :
              is_rfi ? saved_q : inc1;
        take = run && irq && !isr_q && !wfi_go;
        wake = !run && irq;
        adv = run && !wfi_go && !take;
        pc_d = !ce ? pc_q : (take || wake) ? IRQ_VECTOR : adv ? npc : pc_q;
        saved_d = !ce ? saved_q : take ? npc : wake ? inc1 : saved_q;
        isr_d = !ce ? isr_q : (take || wake) ? 1'b1 : (adv && is_rfi) ? 1'b0 : isr_q;
        state_d = !ce ? state_q : wfi_go ? WAIT : wake ? RUN : state_q;
        ack_d = ce && (take || wake);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
            saved_q <= RESET_VECTOR;
            isr_q <= 1'b0;
            state_q <= RUN;
            ack_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            saved_q <= saved_d;
            isr_q <= isr_d;
            state_q <= state_d;
            ack_q <= ack_d;
        end
    end
    assign pc = pc_q;
    assign saved_pc = saved_q;
    assign in_isr = isr_q;
    assign waiting = state_q == WAIT;
    assign irq_ack = ack_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
    logic clk = 1'b0, reset, ce, pc_save, skip, irq;
    logic [1:0] pc_mux;
    logic [11:0] literal, wreg, pc, saved_pc;
    logic in_isr, waiting, irq_ack;
    int n_cmp = 0, n_err = 0;
    always #5 clk = ~clk;
    pc_sequencer dut (
        .clk(clk), .reset(reset), .ce(ce), .pc_mux(pc_mux), .pc_save(pc_save),
        .skip(skip), .literal(literal), .wreg(wreg), .irq(irq),
        .pc(pc), .saved_pc(saved_pc), .in_isr(in_isr), .waiting(waiting), .irq_ack(irq_ack)
    );
    task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask
    task automatic step(input logic [1:0] m, input logic s, input logic sk, input logic i);
        pc_mux = m;
        pc_save = s;
        skip = sk;
        irq = i;
        @(posedge clk);
        #1;
    endtask
    task automatic st(input string tag, input logic [11:0] p, input logic [11:0] sv,
                      input logic isr, input logic w, input logic a);
        chk({tag, "_pc"}, pc, p);
        chk({tag, "_saved"}, saved_pc, sv);
        chk({tag, "_isr"}, 12'(in_isr), 12'(isr));
        chk({tag, "_wait"}, 12'(waiting), 12'(w));
        chk({tag, "_ack"}, 12'(irq_ack), 12'(a));
    endtask
    initial begin
        reset = 1'b1; ce = 1'b0; literal = '0; wreg = '0;
        step(2'd0, 1'b0, 1'b0, 1'b0);
        step(2'd0, 1'b0, 1'b0, 1'b0);
        st("t1_reset", 12'h000, 12'h000, 0, 0, 0);
        reset = 1'b0; ce = 1'b1; literal = 12'hFFE;
        step(2'd2, 1'b0, 1'b0, 1'b0);
        chk("t2_lit", pc, 12'hFFE);
        step(2'd0, 1'b0, 1'b1, 1'b0);
        chk("t2_skipwrap", pc, 12'h000);
        step(2'd0, 1'b0, 1'b0, 1'b0);
        chk("t2_inc", pc, 12'h001);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(2'd2, 1'b0, 1'b1, 1'b1);
            st("t2_stall", 12'h001, 12'h000, 0, 0, 0);
        end
        ce = 1'b1; literal = 12'h123; wreg = 12'h3FF;
        step(2'd2, 1'b0, 1'b1, 1'b0);
        chk("t3_lit", pc, 12'h123);
        step(2'd1, 1'b0, 1'b1, 1'b0);
        chk("t3_wreg", pc, 12'h3FF);
        literal = 12'h050;
        step(2'd2, 1'b0, 1'b0, 1'b0);
        chk("t4_lit", pc, 12'h050);
        step(2'd0, 1'b0, 1'b0, 1'b1);
        st("t4_take", 12'h004, 12'h051, 1, 0, 1);
        step(2'd0, 1'b0, 1'b0, 1'b1);
        st("t4_noretake", 12'h005, 12'h051, 1, 0, 0);
        step(2'd3, 1'b0, 1'b0, 1'b1);
        st("t4_rfi", 12'h051, 12'h051, 0, 0, 0);
        step(2'd0, 1'b0, 1'b0, 1'b1);
        st("t4_retake", 12'h004, 12'h052, 1, 0, 1);
        step(2'd3, 1'b0, 1'b0, 1'b0);
        st("t4_rfi2", 12'h052, 12'h052, 0, 0, 0);
        literal = 12'h020;
        step(2'd2, 1'b0, 1'b0, 1'b0);
        step(2'd3, 1'b1, 1'b0, 1'b0);
        st("t5_wfi", 12'h020, 12'h052, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(2'd2, 1'b0, 1'b1, 1'b0);
            st("t5_hold", 12'h020, 12'h052, 0, 1, 0);
        end
        step(2'd2, 1'b0, 1'b0, 1'b1);
        st("t5_wake", 12'h004, 12'h021, 1, 0, 1);
        step(2'd3, 1'b1, 1'b0, 1'b0);
        st("t5_wfi_isr", 12'h005, 12'h021, 1, 0, 0);
        step(2'd3, 1'b0, 1'b0, 1'b0);
        st("t5_rfi", 12'h021, 12'h021, 0, 0, 0);
        step(2'd3, 1'b1, 1'b0, 1'b1);
        st("t5_wfi_irq", 12'h021, 12'h021, 0, 1, 0);
        step(2'd0, 1'b0, 1'b0, 1'b1);
        st("t5_fastwake", 12'h004, 12'h022, 1, 0, 1);
        step(2'd3, 1'b0, 1'b0, 1'b0);
        st("t5_rfi2", 12'h022, 12'h022, 0, 0, 0);
        step(2'd3, 1'b1, 1'b0, 1'b0);
        chk("t6_wait", 12'(waiting), 12'h001);
        reset = 1'b1;
        step(2'd2, 1'b0, 1'b0, 1'b1);
        st("t6_reset", 12'h000, 12'h000, 0, 0, 0);
        reset = 1'b0; literal = 12'h010;
        step(2'd2, 1'b0, 1'b0, 1'b0);
        chk("t6_lit", pc, 12'h010);
        step(2'd3, 1'b0, 1'b0, 1'b0);
        st("t6_rfi_noisr", 12'h011, 12'h000, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
